alu_div_seq: RTL and testbench
==============================

// Module: alu_div_seq
// PURPOSE
//   Iterative restoring divider for MIPS DIV/DIVU; the subtract-direction companion of the ALU adder.
//   Takes dividend A and divisor B with a Sign select, then produces quotient Q (to LO) and remainder R (to HI).
//   Runs as a multi-cycle unit beside the ALU, so the pipeline stalls on busy until done pulses.
// PARAMETERS
//   WIDTH      32   operand/result width in bits
//   CNT_W      6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1      single clock; all state changes on rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request; accepted only when ready=1
//   A          in   WIDTH  dividend, sampled on accept
//   B          in   WIDTH  divisor, sampled on accept
//   Sign       in   1      1 = signed (DIV), 0 = unsigned (DIVU); sampled on accept
//   ready      out  1      high in IDLE only
//   busy       out  1      high in CALC and FIX
//   done       out  1      one-cycle pulse; Q/R/DZ/V valid from this cycle
//   Q          out  WIDTH  quotient
//   R          out  WIDTH  remainder
//   DZ         out  1      divide-by-zero flag (B==0)
//   V          out  1      signed overflow flag (A=0x80000000, B=0xFFFFFFFF, Sign=1)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; ready=1; busy=0; done=0; Q=R=0; DZ=V=0; counter=0.
//   States and transitions:
//     IDLE -(start & B!=0)-> CALC; IDLE -(start & B==0)-> FIX; IDLE -(!start)-> IDLE.
//     CALC -(counter==WIDTH-1)-> FIX; otherwise stays in CALC with counter+1.
//     FIX -> DONE; DONE -> IDLE (unconditional).
//   Accept edge (IDLE & start): latch Sign, A, B. If Sign=1, also latch |A| and |B| as unsigned magnitudes,
//     with |0x80000000| = 0x80000000. Record negQ = Sign & (A[31]^B[31]) and negR = Sign & A[31].
//     Clear partial remainder; set counter=0; clear DZ and V.
//   CALC, one iteration per cycle, MSB first, WIDTH cycles total:
//     rem' = {rem[W-2:0], dvd[W-1]};
//     if rem' >= dvs then rem = rem' - dvs and the quotient bit is 1, else rem = rem' and the quotient bit is 0;
//     dvd shifts left and takes the quotient bit in at bit 0.
//     The subtract is WIDTH+1 bits wide, so no carry is lost.
//   FIX:
//     Q = negQ ? -quo : quo; R = negR ? -rem : rem.
//     Divide-by-zero path: Q = 32'hFFFFFFFF, R = A as sampled, DZ=1.
//     Signed overflow case: Q=0x80000000, R=0, V=1. This falls out of the magnitude path and must not be special-cased wrongly.
//   DONE: done=1 for exactly one cycle; ready=0.
//   Latency from the accept edge to the cycle with done=1:
//     B!=0: WIDTH+2 edges (34 for WIDTH=32).
//     B==0: 2 edges.
//   Q/R/DZ/V hold their values from DONE until the next accept edge. They never change mid-operation.
//   start while ready=0 (CALC/FIX/DONE) is ignored: no queueing, and A/B/Sign changes have no effect.
//   start held high across the DONE cycle is accepted in the following IDLE cycle. Back-to-back ops are separated by one IDLE cycle.
//   Sign=0: the operands are pure unsigned and negQ=negR=0; A[31]/B[31] carry no meaning.
//   Reset asserted mid-CALC aborts the operation; no done is produced for it.
// STRUCTURE
//   Shared package alu_pkg:
//     div_state_t enum {IDLE, CALC, FIX, DONE}
//     localparams ALU_WIDTH=32, DIV_DZ_Q=32'hFFFFFFFF
//   One sub-module, div_step (combinational): inputs rem, dvd_msb, dvs; outputs rem_next, q_bit.
//     Instantiated once and reused every CALC cycle.
//   Top level holds the FSM, counter, operand registers and the sign fix-up.
// TESTING
//   1. DIVU A=100, B=7 -> done at +34 edges; Q=14, R=2; DZ=0, V=0; busy high for 33 cycles.
//   2. DIV A=-7 (0xFFFFFFF9), B=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1).
//      DIV A=7, B=-2 -> Q=-3, R=1.
//   3. DIV A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, V=1.
//      Same operands with DIVU -> Q=0, R=0x80000000, V=0.
//   4. B=0, A=0x12345678, either Sign -> done at +2 edges; Q=0xFFFFFFFF, R=0x12345678, DZ=1.
//   5. start toggled with new A/B during CALC -> ignored; result matches the first operands.
//      start held through DONE -> second op accepted on the next IDLE cycle.
//   6. reset pulsed at CALC iteration 10 -> all outputs 0 immediately (async), ready=1, no done.
//      Then DIVU 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and width constants.
// Imported by the divider top and its datapath step.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_t;

   localparam int ALU_WIDTH = 32;
   localparam logic [ALU_WIDTH-1:0] DIV_DZ_Q = 32'hFFFFFFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
// Ports: rem/dvd_msb/dvs in; rem_next and q_bit out.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The extra top bit keeps the carry out of the shift; the
   // borrow of the WIDTH+1 bit subtract is the inverse quotient bit.
   always_comb begin
      shifted  = {rem, dvd_msb};
      diff     = shifted - {1'b0, dvs};
      q_bit    = ~diff[WIDTH];
      rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/alu_div_seq.sv
// Iterative restoring divider for DIV/DIVU (Q to LO, R to HI).
// Ports: clk/reset, start/A/B/Sign in; ready/busy/done, Q/R/DZ/V out.
module alu_div_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sign,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DZ,
   output logic             V
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             ovf_q, ovf_d;
   logic             dz_q, dz_d;
   logic             v_q, v_d;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem     (rem_q),
      .dvd_msb (dvd_q[WIDTH-1]),
      .dvs     (dvs_q),
      .rem_next(rem_next),
      .q_bit   (q_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      q_d     = q_q;
      r_d     = r_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      v_d     = v_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = A;
               // Two's-complement negate of MIN_NEG is itself,
               // which is the correct unsigned magnitude.
               dvd_d  = (Sign & A[WIDTH-1]) ? -A : A;
               dvs_d  = (Sign & B[WIDTH-1]) ? -B : B;
               negq_d = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
               negr_d = Sign & A[WIDTH-1];
               ovf_d  = Sign && (A == MIN_NEG) && (B == '1);
               rem_d  = '0;
               cnt_d  = '0;
               dz_d   = 1'b0;
               v_d    = 1'b0;
               state_d = (B == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            rem_d = rem_next;
            dvd_d = {dvd_q[WIDTH-2:0], q_bit};
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FIX: begin
            if (dvs_q == '0) begin
               q_d  = WIDTH'(DIV_DZ_Q);
               r_d  = a_q;
               dz_d = 1'b1;
            end else begin
               // Overflow needs no special case: the magnitude
               // quotient is already MIN_NEG and negQ is 0.
               q_d = negq_q ? -dvd_q : dvd_q;
               r_d = negr_q ? -rem_q : rem_q;
               v_d = ovf_q;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         r_q     <= r_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         v_q     <= v_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign busy  = (state_q == CALC) || (state_q == FIX);
   assign done  = (state_q == DONE);
   assign Q     = q_q;
   assign R     = r_q;
   assign DZ    = dz_q;
   assign V     = v_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: arithmetic reference model
// with per-cycle compare, plus directed hand-computed vectors.
module tb_alu_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        sgn;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;
   logic        dz;
   logic        v;

   int checks = 0;
   int errors = 0;

   alu_div_seq #(
      .WIDTH(32),
      .CNT_W(6)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .A    (a),
      .B    (b),
      .Sign (sgn),
      .ready(ready),
      .busy (busy),
      .done (done),
      .Q    (q),
      .R    (r),
      .DZ   (dz),
      .V    (v)
   );

   always #5 clk = ~clk;

   // Reference result {DZ, V, Q, R} from plain arithmetic.
   function automatic logic [65:0] model(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic s);
      int sx;
      int sy;
      logic [31:0] mq;
      logic [31:0] mr;
      logic mdz;
      logic mv;
      sx  = x;
      sy  = y;
      mdz = 1'b0;
      mv  = 1'b0;
      if (y == 32'h0) begin
         mq  = 32'hFFFFFFFF;
         mr  = x;
         mdz = 1'b1;
      end else if (!s) begin
         mq = x / y;
         mr = x % y;
      end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
         mq = 32'h80000000;
         mr = 32'h0;
         mv = 1'b1;
      end else begin
         mq = sx / sy;
         mr = sx % sy;
      end
      return {mdz, mv, mq, mr};
   endfunction

   // Model of the unit's timing: pend while an op is in flight,
   // done expected in the cycle after edge number "due".
   logic        pend = 1'b0;
   int          ecnt = 0;
   int          due = 0;
   logic [65:0] nxt = '0;
   logic [31:0] mq = '0;
   logic [31:0] mr = '0;
   logic        mdz = 1'b0;
   logic        mv = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pend = 1'b0;
         mq   = '0;
         mr   = '0;
         mdz  = 1'b0;
         mv   = 1'b0;
      end else begin
         ecnt++;
         if (!pend) begin
            if (start) begin
               pend = 1'b1;
               due  = ecnt + ((b == 32'h0) ? 1 : 33);
               nxt  = model(a, b, sgn);
               mdz  = 1'b0;
               mv   = 1'b0;
            end
         end else if (ecnt == due) begin
            {mdz, mv, mq, mr} = nxt;
         end else if (ecnt == due + 1) begin
            pend = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic run_op(input string nm, input logic [31:0] ai,
                         input logic [31:0] bi, input logic si,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input logic ev,
                         input int elat);
      int n;
      int nb;
      @(negedge clk);
      #1;
      a     = ai;
      b     = bi;
      sgn   = si;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n  = 0;
      nb = 0;
      while (n < 50) begin
         @(negedge clk);
         if (done) break;
         if (busy) nb++;
         @(posedge clk);
         n++;
      end
      chk({nm, "_lat"}, 64'(n + 1), 64'(elat));
      chk({nm, "_busy"}, 64'(nb), 64'(elat - 1));
      chk({nm, "_q"}, q, eq);
      chk({nm, "_r"}, r, er);
      chk({nm, "_dz"}, dz, edz);
      chk({nm, "_v"}, v, ev);
   endtask

   initial begin
      int n;
      int cnt;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      sgn   = 1'b0;

      fork
         forever begin
            @(negedge clk);
            chk("cyc_ready", ready, !pend);
            chk("cyc_busy", busy, pend && (ecnt < due));
            chk("cyc_done", done, pend && (ecnt == due));
            chk("cyc_q", q, mq);
            chk("cyc_r", r, mr);
            chk("cyc_dz", dz, mdz);
            chk("cyc_v", v, mv);
         end
      join_none

      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_q", q, 32'h0);
      chk("rst_r", r, 32'h0);
      chk("rst_dzv", {dz, v}, 2'b00);
      #1 reset = 1'b0;

      run_op("divu_100_7", 32'd100, 32'd7, 1'b0,
             32'd14, 32'd2, 1'b0, 1'b0, 34);
      run_op("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
             32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
      run_op("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1,
             32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 34);
      run_op("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
             32'h80000000, 32'h0, 1'b0, 1'b1, 34);
      run_op("divu_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0,
             32'h0, 32'h80000000, 1'b0, 1'b0, 34);
      run_op("divu_dz", 32'h12345678, 32'h0, 1'b0,
             32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 2);
      run_op("div_dz", 32'h12345678, 32'h0, 1'b1,
             32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 2);
      run_op("div_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1,
             32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 34);

      // start with new operands during CALC is ignored; then start
      // held through DONE is taken on the following IDLE cycle.
      @(negedge clk);
      #1;
      a     = 32'd1000;
      b     = 32'd3;
      sgn   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      a     = 32'd5;
      b     = 32'd0;
      sgn   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1;
      a     = 32'd50;
      b     = 32'd6;
      sgn   = 1'b0;
      start = 1'b1;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk);
         n++;
      end
      chk("ign_done", done, 1'b1);
      chk("ign_q", q, 32'd333);
      chk("ign_r", r, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      n = 2;
      while (n < 60) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk);
         n++;
      end
      chk("held_gap", 64'(n), 64'd35);
      chk("held_q", q, 32'd8);
      chk("held_r", r, 32'd2);

      // Async reset in the middle of CALC.
      @(negedge clk);
      #1;
      a     = 32'd100;
      b     = 32'd7;
      sgn   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_ready", ready, 1'b1);
      chk("mid_busy", busy, 1'b0);
      chk("mid_done", done, 1'b0);
      chk("mid_q", q, 32'h0);
      chk("mid_r", r, 32'h0);
      chk("mid_dzv", {dz, v}, 2'b00);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("mid_nodone", 64'(cnt), 64'd0);

      run_op("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0,
             32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 34);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
